// File: rtl/lcd_tgen.sv
// lcd_tgen: parametrised panel timing and RGB test-pattern generator.
// Build option: define PGEN_SCROLL_EN to scroll the pattern one pixel per frame.
module lcd_tgen #(
  parameter int unsigned P_DAT_BIT = 6,
  parameter int unsigned H_ACTIVE  = 480,
  parameter int unsigned H_FP      = 2,
  parameter int unsigned H_SYNC    = 41,
  parameter int unsigned H_BP      = 2,
  parameter int unsigned V_ACTIVE  = 272,
  parameter int unsigned V_FP      = 2,
  parameter int unsigned V_SYNC    = 10,
  parameter int unsigned V_BP      = 2,
  parameter bit          HS_POL    = 1'b0,
  parameter bit          VS_POL    = 1'b0,
  parameter int unsigned CHK_LOG2  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [1:0]           mode,
  output logic                 vs_out,
  output logic                 hs_out,
  output logic                 de_out,
  output logic [P_DAT_BIT-1:0] rdata_out,
  output logic [P_DAT_BIT-1:0] gdata_out,
  output logic [P_DAT_BIT-1:0] bdata_out,
  output logic                 xstby,
  output logic                 rev,
  output logic [7:0]           frame_cnt
);

  localparam int unsigned HT =
    H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned VT =
    V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int unsigned HW = $clog2(HT);
  localparam int unsigned VW = $clog2(VT);
  localparam int unsigned XW = $clog2(H_ACTIVE + 1);
  localparam int unsigned YW = $clog2(V_ACTIVE + 1);
  localparam int          BAR_W = H_ACTIVE / 8;

  localparam logic [HW-1:0] H_SE   = HW'(H_SYNC);
  localparam logic [HW-1:0] H_AB   = HW'(H_SYNC + H_BP);
  localparam logic [HW-1:0] H_AN   = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_LAST = HW'(HT - 1);
  localparam logic [VW-1:0] V_SE   = VW'(V_SYNC);
  localparam logic [VW-1:0] V_AB   = VW'(V_SYNC + V_BP);
  localparam logic [VW-1:0] V_AN   = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_LAST = VW'(VT - 1);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t state;
  state_t state_nx;

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic [HW-1:0] hx;
  logic [VW-1:0] vy;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [XW-1:0] px;
  logic          h_act;
  logic          v_act;

  logic          run;
  logic          last;
  logic          fstart;
  logic          inc;
  logic          first_q;
  logic [1:0]    mode_q;

  logic          s1_hs;
  logic          s1_vs;
  logic          s1_de;
  logic [XW-1:0] s1_x;
  logic [YW-1:0] s1_y;
  logic [1:0]    s1_mode;

  logic [2:0]    idx;
  logic [XW+P_DAT_BIT-1:0] xe;
  logic [XW-1:0] xs;
  logic [YW-1:0] ys;
  logic [P_DAT_BIT-1:0] pr;
  logic [P_DAT_BIT-1:0] pg;
  logic [P_DAT_BIT-1:0] pb;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // start on en, stop only at the last clock of a frame
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (en) state_nx = S_RUN;
      S_RUN:  if (last && !en) state_nx = S_IDLE;
    endcase
  end

  // FSM-derived control strobes
  always_comb begin
    run    = (state == S_RUN);
    last   = (hcnt == H_LAST) && (vcnt == V_LAST);
    fstart = run && (hcnt == '0) && (vcnt == '0);
    inc    = fstart && !first_q;
  end

  // raster counters, parked at zero while idle
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  // active-region decode and pixel coordinates
  always_comb begin
    hx    = hcnt - H_AB;
    vy    = vcnt - V_AB;
    h_act = (hcnt >= H_AB) && (hx < H_AN);
    v_act = (vcnt >= V_AB) && (vy < V_AN);
    x     = hx[XW-1:0];
    y     = vy[YW-1:0];
  end

  // frame-start bookkeeping: mode latch, frame count, rev, standby
  always_ff @(posedge clk) begin
    if (rst) begin
      xstby     <= 1'b0;
      frame_cnt <= '0;
      rev       <= 1'b0;
      mode_q    <= '0;
      first_q   <= 1'b1;
    end else begin
      xstby <= (state_nx == S_RUN);
      if (!run) begin
        first_q <= 1'b1;
      end else if (fstart) begin
        mode_q  <= mode;
        first_q <= 1'b0;
        if (!first_q) begin
          frame_cnt <= frame_cnt + 1'b1;
          rev       <= ~rev;
        end
      end
    end
  end

`ifdef PGEN_SCROLL_EN
  localparam int unsigned XW1 = XW + 1;
  localparam logic [XW:0]   HA_C  = XW1'(H_ACTIVE);
  localparam logic [XW-1:0] HA_M1 = XW'(H_ACTIVE - 1);

  logic [XW-1:0] off;
  logic [XW:0]   sum;

  // off mirrors frame_cnt mod H_ACTIVE without a divider
  always_ff @(posedge clk) begin
    if (rst) begin
      off <= '0;
    end else if (inc) begin
      if (frame_cnt == 8'hff || off == HA_M1)
        off <= '0;
      else
        off <= off + 1'b1;
    end
  end

  // scrolled x: one conditional subtract wraps the sum
  always_comb begin
    sum = {1'b0, x} + {1'b0, off};
    if (sum >= HA_C) sum = sum - HA_C;
    px = sum[XW-1:0];
  end
`else
  // pattern uses the raw x coordinate
  always_comb px = x;
`endif

  // stage 1: register timing flags and pattern coordinates
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_hs   <= 1'b0;
      s1_vs   <= 1'b0;
      s1_de   <= 1'b0;
      s1_x    <= '0;
      s1_y    <= '0;
      s1_mode <= '0;
    end else begin
      s1_hs   <= run && (hcnt < H_SE);
      s1_vs   <= run && (vcnt < V_SE);
      s1_de   <= run && h_act && v_act;
      s1_x    <= px;
      s1_y    <= y;
      s1_mode <= mode_q;
    end
  end

  // pattern generator
  always_comb begin
    pr  = '0;
    pg  = '0;
    pb  = '0;
    idx = '0;
    for (int k = 1; k < 8; k++)
      if (int'(s1_x) >= k * BAR_W) idx = idx + 3'd1;
    xe = {{P_DAT_BIT{1'b0}}, s1_x};
    xs = s1_x >> CHK_LOG2;
    ys = s1_y >> CHK_LOG2;
    unique case (1'b1)
      (s1_mode == 2'd0): begin
        pr = {P_DAT_BIT{~idx[1]}};
        pg = {P_DAT_BIT{~idx[2]}};
        pb = {P_DAT_BIT{~idx[0]}};
      end
      (s1_mode == 2'd1): begin
        pr = xe[P_DAT_BIT-1:0];
        pg = xe[P_DAT_BIT-1:0];
        pb = xe[P_DAT_BIT-1:0];
      end
      (s1_mode == 2'd2): begin
        pr = {P_DAT_BIT{xs[0] ^ ys[0]}};
        pg = {P_DAT_BIT{xs[0] ^ ys[0]}};
        pb = {P_DAT_BIT{xs[0] ^ ys[0]}};
      end
      default: begin
        pr = '1;
        pg = '1;
        pb = '1;
      end
    endcase
  end

  // stage 2: polarity, data blanking, output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_out    <= ~HS_POL;
      vs_out    <= ~VS_POL;
      de_out    <= 1'b0;
      rdata_out <= '0;
      gdata_out <= '0;
      bdata_out <= '0;
    end else begin
      hs_out    <= s1_hs ? HS_POL : ~HS_POL;
      vs_out    <= s1_vs ? VS_POL : ~VS_POL;
      de_out    <= s1_de;
      rdata_out <= s1_de ? pr : '0;
      gdata_out <= s1_de ? pg : '0;
      bdata_out <= s1_de ? pb : '0;
    end
  end

endmodule

// File: tb/tb_lcd_tgen.sv
// tb_lcd_tgen: directed + random bench for lcd_tgen
// against a frame-position reference model.
module tb_lcd_tgen;

  localparam int HA  = 16;
  localparam int HFP = 2;
  localparam int HSY = 3;
  localparam int HBP = 3;
  localparam int VA  = 4;
  localparam int VFP = 1;
  localparam int VSY = 1;
  localparam int VBP = 1;
  localparam int CHK = 1;
  localparam int HT  = HSY + HBP + HA + HFP;
  localparam int VT  = VSY + VBP + VA + VFP;
  localparam int FT  = HT * VT;
  localparam bit HPOL = 1'b0;
  localparam bit VPOL = 1'b0;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic       vs_out;
  logic       hs_out;
  logic       de_out;
  logic [5:0] rdata_out;
  logic [5:0] gdata_out;
  logic [5:0] bdata_out;
  logic       xstby;
  logic       rev;
  logic [7:0] frame_cnt;

  always #5 clk = ~clk;

  lcd_tgen #(
    .P_DAT_BIT(6),
    .H_ACTIVE(HA), .H_FP(HFP),
    .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP),
    .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(HPOL), .VS_POL(VPOL),
    .CHK_LOG2(CHK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .mode(mode),
    .vs_out(vs_out),
    .hs_out(hs_out),
    .de_out(de_out),
    .rdata_out(rdata_out),
    .gdata_out(gdata_out),
    .bdata_out(bdata_out),
    .xstby(xstby),
    .rev(rev),
    .frame_cnt(frame_cnt)
  );

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic [5:0] r;
    logic [5:0] g;
    logic [5:0] b;
  } rec_t;

  int   n_asrt = 0;
  int   n_fail = 0;

  bit   m_run;
  int   m_pos;
  bit   m_first;
  int   m_fc;
  bit   m_rev;
  int   m_mode;
  bit   m_xstby;
  rec_t m_s1;
  rec_t m_out;

  function automatic logic [2:0] bar_rgb(int b);
    case (b)
      0: return 3'b111;
      1: return 3'b110;
      2: return 3'b011;
      3: return 3'b010;
      4: return 3'b101;
      5: return 3'b100;
      6: return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  function automatic rec_t idle_rec();
    rec_t o;
    o.hs = ~HPOL;
    o.vs = ~VPOL;
    o.de = 1'b0;
    o.r  = '0;
    o.g  = '0;
    o.b  = '0;
    return o;
  endfunction

  function automatic rec_t decode(bit run, int pos, int md, int fc);
    rec_t o;
    int h, v, x, y, sx, bi;
    logic [2:0] c;
    logic [5:0] px;
    o = idle_rec();
    if (!run) return o;
    h = pos % HT;
    v = pos / HT;
    o.hs = (h < HSY) ? HPOL : ~HPOL;
    o.vs = (v < VSY) ? VPOL : ~VPOL;
    x = h - (HSY + HBP);
    y = v - (VSY + VBP);
    if (x < 0 || x >= HA || y < 0 || y >= VA) return o;
    o.de = 1'b1;
`ifdef PGEN_SCROLL_EN
    sx = (x + fc) % HA;
`else
    sx = x + 0 * fc;
`endif
    case (md)
      0: begin
        bi = sx / (HA / 8);
        if (bi > 7) bi = 7;
        c = bar_rgb(bi);
        o.r = c[2] ? 6'h3f : 6'h00;
        o.g = c[1] ? 6'h3f : 6'h00;
        o.b = c[0] ? 6'h3f : 6'h00;
      end
      1: begin
        px = 6'(sx % 64);
        o.r = px;
        o.g = px;
        o.b = px;
      end
      2: begin
        px = ((((sx >> CHK) ^ (y >> CHK)) & 1) != 0) ? 6'h3f : 6'h00;
        o.r = px;
        o.g = px;
        o.b = px;
      end
      default: begin
        o.r = 6'h3f;
        o.g = 6'h3f;
        o.b = 6'h3f;
      end
    endcase
    return o;
  endfunction

  task automatic model_edge();
    bit nrun;
    if (rst) begin
      m_run = 0; m_pos = 0; m_first = 1;
      m_fc = 0; m_rev = 0; m_mode = 0;
      m_xstby = 0;
      m_s1 = idle_rec();
      m_out = idle_rec();
      return;
    end
    m_out = m_s1;
    m_s1 = decode(m_run, m_pos, m_mode, m_fc);
    if (m_run && m_pos == 0) begin
      if (!m_first) begin
        m_fc = (m_fc + 1) % 256;
        m_rev = !m_rev;
      end
      m_mode = int'(mode);
      m_first = 0;
    end
    if (!m_run) m_first = 1;
    nrun = m_run ? !(m_pos == FT - 1 && !en) : en;
    m_pos = m_run ? (m_pos + 1) % FT : 0;
    m_run = nrun;
    m_xstby = nrun;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("hs_out", 32'(hs_out), 32'(m_out.hs));
    chk("vs_out", 32'(vs_out), 32'(m_out.vs));
    chk("de_out", 32'(de_out), 32'(m_out.de));
    chk("rdata", 32'(rdata_out), 32'(m_out.r));
    chk("gdata", 32'(gdata_out), 32'(m_out.g));
    chk("bdata", 32'(bdata_out), 32'(m_out.b));
    chk("xstby", 32'(xstby), 32'(m_xstby));
    chk("rev", 32'(rev), 32'(m_rev));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_fc));
  endtask

  task automatic cyc(bit r, bit e, logic [1:0] md);
    rst  = r;
    en   = e;
    mode = md;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int n;
    bit e;
    rst = 1'b1; en = 1'b0; mode = 2'd0;

    // reset and idle
    repeat (5) cyc(1'b1, 1'b0, 2'd0);
    chk("rst_hs", 32'(hs_out), 32'd1);
    chk("rst_vs", 32'(vs_out), 32'd1);
    chk("rst_xstby", 32'(xstby), 32'd0);
    repeat (200) cyc(1'b0, 1'b0, 2'd0);
    chk("idle_de", 32'(de_out), 32'd0);
    chk("idle_fc", 32'(frame_cnt), 32'd0);

    // first de: en edge, 54 counter steps to (h6,v2), 2 pipe
    n = 0;
    do begin
      cyc(1'b0, 1'b1, 2'd0);
      n++;
    end while (de_out !== 1'b1 && n < 400);
    chk("first_de_lat", 32'(n), 32'd57);
    chk("bar0_r", 32'(rdata_out), 32'd63);
    chk("bar0_b", 32'(bdata_out), 32'd63);

    // bars, then ramp selected mid-frame, checker, white
    repeat (FT + 30) cyc(1'b0, 1'b1, 2'd0);
    repeat (2 * FT) cyc(1'b0, 1'b1, 2'd1);
    repeat (2 * FT) cyc(1'b0, 1'b1, 2'd2);
    repeat (FT) cyc(1'b0, 1'b1, 2'd3);

    // stop at clock 50 of frame 3, finish frame, restart
    cyc(1'b1, 1'b0, 2'd0);
    repeat (1 + 2 * FT + 50) cyc(1'b0, 1'b1, 2'd0);
    n = 0;
    do begin
      cyc(1'b0, 1'b0, 2'd0);
      n++;
    end while (xstby !== 1'b0 && n < 400);
    chk("stop_len", 32'(n), 32'd118);
    chk("stop_fc", 32'(frame_cnt), 32'd2);
    chk("stop_rev", 32'(rev), 32'd0);
    repeat (20) cyc(1'b0, 1'b0, 2'd0);
    chk("idle2_xstby", 32'(xstby), 32'd0);
    repeat (100) cyc(1'b0, 1'b1, 2'd1);
    chk("restart_fc", 32'(frame_cnt), 32'd2);
    repeat (75) cyc(1'b0, 1'b1, 2'd1);
    chk("restart_fc2", 32'(frame_cnt), 32'd3);
    chk("restart_rev", 32'(rev), 32'd1);

    // reset mid-frame
    repeat (80) cyc(1'b0, 1'b1, 2'd2);
    cyc(1'b1, 1'b1, 2'd2);
    chk("mrst_hs", 32'(hs_out), 32'd1);
    chk("mrst_vs", 32'(vs_out), 32'd1);
    chk("mrst_de", 32'(de_out), 32'd0);
    chk("mrst_r", 32'(rdata_out), 32'd0);
    chk("mrst_xstby", 32'(xstby), 32'd0);
    chk("mrst_fc", 32'(frame_cnt), 32'd0);

    // random run requests, modes and rare resets
    e = 1'b1;
    repeat (4000) begin
      if ($urandom_range(0, 199) == 0) e = !e;
      cyc($urandom_range(0, 1499) == 0, e,
          2'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
